// File: rtl/countdown_ctrl_if.sv
// rtl/countdown_ctrl_if.sv - key/tick inputs and display/status outputs of countdown_ctrl
interface countdown_ctrl_if #(
  parameter int NDIG = 3
);
  logic                tick_in;
  logic                key_valid;
  logic [3:0]          key_code;
  logic [4*NDIG-1:0]   disp;
  logic [1:0]          state;
  logic                running;
  logic                alarm;
  logic                done_pulse;

  modport master (
    output tick_in, key_valid, key_code,
    input  disp, state, running, alarm, done_pulse
  );

  modport slave (
    input  tick_in, key_valid, key_code,
    output disp, state, running, alarm, done_pulse
  );
endinterface

// File: rtl/countdown_ctrl.sv
// rtl/countdown_ctrl.sv - IR-key driven BCD countdown sequencer (optional COUNTDOWN_AUTORELOAD_EN)
module countdown_ctrl #(
  parameter int         NDIG        = 3,
  parameter int         ALARM_TICKS = 200,
  parameter logic [3:0] KEY_START   = 4'hA,
  parameter logic [3:0] KEY_CLEAR   = 4'hB,
  parameter logic [3:0] KEY_RELOAD  = 4'hC
) (
  input  logic             clk,
  input  logic             rst,
  countdown_ctrl_if.slave  bus
);
  localparam int W = 4 * NDIG;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         state_q;
  logic [W-1:0]   entry_q;
  logic [W-1:0]   count_q;
  logic [15:0]    alarm_timer_q;
  logic           alarm_q;
  logic           done_pulse_q;

  logic           key_digit;
  logic           key_start;
  logic           key_clear;
  logic           key_reload;
  logic [W-1:0]   entry_shift;
  logic [W-1:0]   count_dec;
  logic           reach_zero;
  logic [15:0]    timer_dec;

  // Ripple-borrow BCD decrement: a zero digit becomes 9 and passes the borrow up.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    key_digit   = bus.key_valid && (bus.key_code <= 4'd9);
    key_start   = bus.key_valid && (bus.key_code == KEY_START);
    key_clear   = bus.key_valid && (bus.key_code == KEY_CLEAR);
    key_reload  = bus.key_valid && (bus.key_code == KEY_RELOAD);
    entry_shift = (entry_q << 4) | W'(bus.key_code);
    count_dec   = bcd_dec(count_q);
    // A zero count (reloaded from an empty entry) also terminates rather than wrapping.
    reach_zero  = (count_dec == '0) || (count_q == '0);
    timer_dec   = alarm_timer_q - 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      entry_q       <= '0;
      count_q       <= '0;
      alarm_timer_q <= '0;
      alarm_q       <= 1'b0;
      done_pulse_q  <= 1'b0;
    end else begin
      done_pulse_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (key_digit) begin
            entry_q <= entry_shift;
          end else if (key_start) begin
            if (entry_q != '0) begin
              count_q <= entry_q;
              state_q <= S_RUN;
            end
          end else if (key_clear) begin
            entry_q <= '0;
          end else if (key_reload) begin
            count_q <= entry_q;
          end
        end

        S_RUN: begin
          // Any valid key takes priority and swallows a coincident tick.
          if (bus.key_valid) begin
            if (key_start) begin
              state_q <= S_PAUSE;
            end else if (key_clear) begin
              count_q <= '0;
              entry_q <= '0;
              state_q <= S_IDLE;
            end else if (key_reload) begin
              count_q <= entry_q;
            end
          end else if (bus.tick_in) begin
            if (reach_zero) begin
              done_pulse_q <= 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
              count_q       <= entry_q;
`else
              count_q       <= '0;
              alarm_timer_q <= 16'(ALARM_TICKS);
              alarm_q       <= 1'b1;
              state_q       <= S_DONE;
`endif
            end else begin
              count_q <= count_dec;
            end
          end
        end

        S_PAUSE: begin
          if (key_start) begin
            state_q <= S_RUN;
          end else if (key_clear) begin
            count_q <= '0;
            entry_q <= '0;
            state_q <= S_IDLE;
          end else if (key_reload) begin
            count_q <= entry_q;
          end
        end

        S_DONE: begin
          if (bus.key_valid || (bus.tick_in && alarm_timer_q == 16'd0)) begin
            alarm_q       <= 1'b0;
            alarm_timer_q <= '0;
            count_q       <= entry_q;
            state_q       <= S_IDLE;
          end else if (bus.tick_in) begin
            alarm_timer_q <= timer_dec;
            alarm_q       <= (timer_dec != 16'd0);
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.disp       = (state_q == S_IDLE) ? entry_q : count_q;
  assign bus.state      = state_q;
  assign bus.running    = (state_q == S_RUN);
  assign bus.alarm      = alarm_q;
  assign bus.done_pulse = done_pulse_q;
endmodule

// File: tb/tb_countdown_ctrl.sv
// tb/tb_countdown_ctrl.sv - directed self-checking bench for countdown_ctrl
module tb_countdown_ctrl;
  localparam logic [3:0] K_START  = 4'hA;
  localparam logic [3:0] K_CLEAR  = 4'hB;
  localparam logic [3:0] K_RELOAD = 4'hC;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   pulses;

  countdown_ctrl_if #(.NDIG(3)) bus ();

  countdown_ctrl #(
    .NDIG(3),
    .ALARM_TICKS(4),
    .KEY_START(K_START),
    .KEY_CLEAR(K_CLEAR),
    .KEY_RELOAD(K_RELOAD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic kv, input logic [3:0] kc, input logic tk);
    bus.key_valid = kv;
    bus.key_code  = kc;
    bus.tick_in   = tk;
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    bus.tick_in   = 1'b0;
  endtask

  task automatic key(input logic [3:0] kc);
    cyc(1'b1, kc, 1'b0);
  endtask

  task automatic tick();
    cyc(1'b0, 4'h0, 1'b1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    bus.tick_in   = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_disp", 32'(bus.disp), 32'h000);
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_running", 32'(bus.running), 32'd0);
    chk("rst_alarm", 32'(bus.alarm), 32'd0);
    chk("rst_pulse", 32'(bus.done_pulse), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    key(4'd1); key(4'd2); key(4'd3);
    chk("entry_123", 32'(bus.disp), 32'h123);
    chk("entry_state", 32'(bus.state), 32'd0);
    key(4'd4);
    chk("entry_shift_234", 32'(bus.disp), 32'h234);
    key(4'hE);
    chk("ignore_code_E", 32'(bus.disp), 32'h234);
    key(K_CLEAR);
    chk("idle_clear", 32'(bus.disp), 32'h000);
    key(K_START);
    chk("start_zero_ignored", 32'(bus.state), 32'd0);

`ifndef COUNTDOWN_AUTORELOAD_EN
    key(4'd3);
    key(K_START);
    chk("start_state", 32'(bus.state), 32'd1);
    chk("start_running", 32'(bus.running), 32'd1);
    chk("start_disp", 32'(bus.disp), 32'h003);
    tick();
    chk("dec_002", 32'(bus.disp), 32'h002);
    tick();
    chk("dec_001", 32'(bus.disp), 32'h001);
    chk("no_pulse_early", 32'(bus.done_pulse), 32'd0);
    tick();
    chk("dec_000", 32'(bus.disp), 32'h000);
    chk("done_state", 32'(bus.state), 32'd3);
    chk("done_pulse", 32'(bus.done_pulse), 32'd1);
    chk("done_alarm", 32'(bus.alarm), 32'd1);
    chk("done_running", 32'(bus.running), 32'd0);
    repeat (3) tick();
    chk("pulse_once", 32'(bus.done_pulse), 32'd0);
    chk("alarm_after3", 32'(bus.alarm), 32'd1);
    tick();
    chk("alarm_fall", 32'(bus.alarm), 32'd0);
    chk("still_done", 32'(bus.state), 32'd3);
    tick();
    chk("timer_exit_state", 32'(bus.state), 32'd0);
    chk("timer_exit_disp", 32'(bus.disp), 32'h003);

    key(K_START);
    repeat (3) tick();
    chk("done_again", 32'(bus.state), 32'd3);
    key(4'd7);
    chk("ack_state", 32'(bus.state), 32'd0);
    chk("ack_entry", 32'(bus.disp), 32'h003);
    chk("ack_alarm", 32'(bus.alarm), 32'd0);
`else
    key(4'd2);
    key(K_START);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.done_pulse) pulses++;
    end
    chk("auto_pulses", 32'(pulses), 32'd3);
    chk("auto_state", 32'(bus.state), 32'd1);
    chk("auto_disp", 32'(bus.disp), 32'h002);
    chk("auto_alarm", 32'(bus.alarm), 32'd0);
`endif

    key(K_CLEAR);
    chk("clear_state", 32'(bus.state), 32'd0);
    key(4'd1); key(4'd0); key(4'd0);
    chk("entry_100", 32'(bus.disp), 32'h100);
    key(K_START);
    tick();
    chk("borrow_099", 32'(bus.disp), 32'h099);
    key(K_START);
    chk("pause_state", 32'(bus.state), 32'd2);
    repeat (5) tick();
    chk("pause_frozen", 32'(bus.disp), 32'h099);
    chk("pause_state_hold", 32'(bus.state), 32'd2);
    key(K_START);
    chk("resume_state", 32'(bus.state), 32'd1);
    key(K_RELOAD);
    chk("reload_run", 32'(bus.disp), 32'h100);
    chk("reload_run_state", 32'(bus.state), 32'd1);
    key(4'd5);
    chk("digit_ignored_run", 32'(bus.disp), 32'h100);
    repeat (99) tick();
    chk("count_001", 32'(bus.disp), 32'h001);
    cyc(1'b1, K_START, 1'b1);
    chk("coinc_state", 32'(bus.state), 32'd2);
    chk("coinc_disp", 32'(bus.disp), 32'h001);
    chk("coinc_pulse", 32'(bus.done_pulse), 32'd0);
    key(K_CLEAR);
    chk("pause_clear_state", 32'(bus.state), 32'd0);
    chk("pause_clear_disp", 32'(bus.disp), 32'h000);

    key(4'd0); key(4'd4); key(4'd2);
    key(K_START);
    chk("run_042", 32'(bus.disp), 32'h042);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("async_disp", 32'(bus.disp), 32'h000);
    chk("async_state", 32'(bus.state), 32'd0);
    chk("async_running", 32'(bus.running), 32'd0);
    chk("async_alarm", 32'(bus.alarm), 32'd0);
    #5 rst = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
